// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write-port arbiter.
package axi_arb_pkg;

    // Arbiter FSM: waiting for a request, or forwarding the granted master's write
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Master index storage width, sized for the largest supported N_MST (8)
    localparam int unsigned MST_IDX_W = 3;

    typedef logic [MST_IDX_W-1:0] mst_idx_t;

    // Index width that stays at least one bit wide for n <= 1
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_idx_fifo.sv
// In-order FIFO of granted master indices; the head selects the B-response owner.
module arb_idx_fifo
    import axi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  mst_idx_t                 push_idx,
    input  logic                     pop,
    output mst_idx_t                 head_idx,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    mst_idx_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_W'(DEPTH));
    assign count    = r_count;
    assign head_idx = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_idx;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-like write port among N_MST masters.
// The grant is held until both the AW handshake and the wlast beat complete;
// B responses are routed back through an in-order FIFO of master indices.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned N_MST     = 4,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MST-1:0]              m_awvalid,
    input  logic [N_MST*ADDR_W-1:0]       m_awaddr,
    output logic [N_MST-1:0]              m_awready,
    input  logic [N_MST-1:0]              m_wvalid,
    input  logic [N_MST*DATA_W-1:0]       m_wdata,
    input  logic [N_MST-1:0]              m_wlast,
    output logic [N_MST-1:0]              m_wready,
    output logic [N_MST-1:0]              m_bvalid,
    input  logic [N_MST-1:0]              m_bready,
    output logic                          s_awvalid,
    output logic [ADDR_W-1:0]             s_awaddr,
    input  logic                          s_awready,
    output logic                          s_wvalid,
    output logic [DATA_W-1:0]             s_wdata,
    output logic                          s_wlast,
    input  logic                          s_wready,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic                          grant_valid,
    output logic [$clog2(N_MST)-1:0]      grant_idx,
    output logic [$clog2(MAX_OUTST):0]    outst_cnt,
    output logic                          err_unexp_b
);

    localparam int unsigned IDX_W = $clog2(N_MST);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    arb_state_e         r_state;
    logic               r_grant_valid;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_aw_done;
    logic               r_w_done;
    logic               r_err_unexp_b;

    logic [IDX_W:0]     w_pick;
    logic [IDX_W-1:0]   w_win;
    logic               w_arb_go;
    logic               w_aw_hs;
    logic               w_wlast_hs;
    logic               w_pop;
    mst_idx_t           w_fifo_head;
    logic [IDX_W-1:0]   w_head;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [CNT_W-1:0]   w_fifo_count;

    // First requester at or after ptr, wrapping; returns {found, index}
    function automatic logic [IDX_W:0] rr_pick(input logic [N_MST-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        int unsigned    k;
        logic [IDX_W:0] res;
        res = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            k = 32'(ptr) + i;
            if (k >= N_MST) begin
                k = k - N_MST;
            end
            if (!res[IDX_W] && req[IDX_W'(k)]) begin
                res = {1'b1, IDX_W'(k)};
            end
        end
        return res;
    endfunction

    assign w_pick     = rr_pick(m_awvalid, r_rr_ptr);
    assign w_win      = w_pick[IDX_W-1:0];
    assign w_arb_go   = (r_state == IDLE) & w_pick[IDX_W] & ~w_fifo_full;
    assign w_aw_hs    = s_awvalid & s_awready;
    assign w_wlast_hs = s_wvalid & s_wready & s_wlast;
    assign w_pop      = s_bvalid & s_bready;
    assign w_head     = IDX_W'(w_fifo_head);

    // Forward AW and W of the granted master; everything idles without a grant
    always_comb begin
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wlast   = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (r_grant_valid && (r_grant_idx == IDX_W'(i))) begin
                s_awvalid    = m_awvalid[i] & ~r_aw_done;
                s_awaddr     = m_awaddr[i*ADDR_W +: ADDR_W];
                s_wvalid     = m_wvalid[i] & ~r_w_done;
                s_wdata      = m_wdata[i*DATA_W +: DATA_W];
                s_wlast      = m_wlast[i];
                m_awready[i] = s_awready & ~r_aw_done;
                m_wready[i]  = s_wready & ~r_w_done;
            end
        end
    end

    // Route B to the master at the FIFO head; stray responses are not accepted
    always_comb begin
        m_bvalid = '0;
        s_bready = 1'b0;
        if (!w_fifo_empty) begin
            m_bvalid[w_head] = s_bvalid;
            s_bready         = m_bready[w_head];
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until AW and last W are both done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_rr_ptr      <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_go) begin
                        r_state       <= XFER;
                        r_grant_valid <= 1'b1;
                        r_grant_idx   <= w_win;
                        r_aw_done     <= 1'b0;
                        r_w_done      <= 1'b0;
                        r_rr_ptr      <= (w_win == IDX_W'(N_MST - 1)) ? '0 : w_win + IDX_W'(1);
                    end
                end
                XFER: begin
                    r_aw_done <= r_aw_done | w_aw_hs;
                    r_w_done  <= r_w_done | w_wlast_hs;
                    if ((r_aw_done | w_aw_hs) && (r_w_done | w_wlast_hs)) begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky flag for a B response arriving with nothing outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_unexp_b <= 1'b0;
        end else if (s_bvalid && w_fifo_empty) begin
            r_err_unexp_b <= 1'b1;
        end
    end

    arb_idx_fifo #(
        .DEPTH    (MAX_OUTST)
    ) u_idx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_aw_hs),
        .push_idx (MST_IDX_W'(r_grant_idx)),
        .pop      (w_pop),
        .head_idx (w_fifo_head),
        .empty    (w_fifo_empty),
        .full     (w_fifo_full),
        .count    (w_fifo_count)
    );

    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign outst_cnt   = w_fifo_count;
    assign err_unexp_b = r_err_unexp_b;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (4 masters, 4 outstanding).
module tb_axi_wr_arbiter;

    logic           clk;
    logic           rst;
    logic [3:0]     m_awvalid;
    logic [127:0]   m_awaddr;
    logic [3:0]     m_awready;
    logic [3:0]     m_wvalid;
    logic [127:0]   m_wdata;
    logic [3:0]     m_wlast;
    logic [3:0]     m_wready;
    logic [3:0]     m_bvalid;
    logic [3:0]     m_bready;
    logic           s_awvalid;
    logic [31:0]    s_awaddr;
    logic           s_awready;
    logic           s_wvalid;
    logic [31:0]    s_wdata;
    logic           s_wlast;
    logic           s_wready;
    logic           s_bvalid;
    logic           s_bready;
    logic           grant_valid;
    logic [1:0]     grant_idx;
    logic [2:0]     outst_cnt;
    logic           err_unexp_b;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;
    int b0       = 0;

    axi_wr_arbiter #(
        .N_MST     (4),
        .MAX_OUTST (4),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_awvalid   (m_awvalid),
        .m_awaddr    (m_awaddr),
        .m_awready   (m_awready),
        .m_wvalid    (m_wvalid),
        .m_wdata     (m_wdata),
        .m_wlast     (m_wlast),
        .m_wready    (m_wready),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .s_awvalid   (s_awvalid),
        .s_awaddr    (s_awaddr),
        .s_awready   (s_awready),
        .s_wvalid    (s_wvalid),
        .s_wdata     (s_wdata),
        .s_wlast     (s_wlast),
        .s_wready    (s_wready),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .outst_cnt   (outst_cnt),
        .err_unexp_b (err_unexp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; count W handshakes present just before the edge
    task automatic cyc();
        if (s_wvalid && s_wready) beats++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mst(input int m, input logic av, input logic wv, input logic wl,
                           input logic [31:0] a, input logic [31:0] d);
        m_awvalid[m]         = av;
        m_wvalid[m]          = wv;
        m_wlast[m]           = wl;
        m_awaddr[m*32 +: 32] = a;
        m_wdata[m*32 +: 32]  = d;
    endtask

    // Single-beat write from master m with AW and W presented together
    task automatic single_write(input int m, input logic [31:0] a, input logic [31:0] d);
        logic [1:0] mi;
        mi = 2'(m);
        set_mst(m, 1'b1, 1'b1, 1'b1, a, d);
        #1;
        cyc();
        chk("sw_gvalid", grant_valid, 1);
        chk("sw_gidx", grant_idx, mi);
        chk("sw_awaddr", s_awaddr, a);
        cyc();
        set_mst(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("sw_release", grant_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Masters 1 and 2 request together; expect grants 1 then 2 with one idle cycle
    task automatic pair_12(input string p);
        set_mst(1, 1'b1, 1'b1, 1'b1, 32'h2000, 32'h21);
        set_mst(2, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h31);
        #1;
        cyc();
        chk({p, "_g1_valid"}, grant_valid, 1);
        chk({p, "_g1_idx"}, grant_idx, 2'd1);
        chk({p, "_g1_addr"}, s_awaddr, 32'h2000);
        cyc();
        set_mst(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk({p, "_gap"}, grant_valid, 0);
        cyc();
        chk({p, "_g2_valid"}, grant_valid, 1);
        chk({p, "_g2_idx"}, grant_idx, 2'd2);
        chk({p, "_g2_addr"}, s_awaddr, 32'h3000);
        cyc();
        set_mst(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk({p, "_done"}, grant_valid, 0);
        chk({p, "_outst2"}, outst_cnt, 3'd2);
        s_bvalid = 1'b1;
        #1;
        chk({p, "_b_m1"}, m_bvalid, 4'b0010);
        cyc();
        chk({p, "_b_m2"}, m_bvalid, 4'b0100);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk({p, "_outst0"}, outst_cnt, 3'd0);
    endtask

    initial begin
        rst       = 1'b1;
        m_awvalid = '0;
        m_awaddr  = '0;
        m_wvalid  = '0;
        m_wdata   = '0;
        m_wlast   = '0;
        m_bready  = 4'b1111;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bvalid  = 1'b0;
        #3;

        // Reset state
        chk("rst_gvalid", grant_valid, 0);
        chk("rst_gidx", grant_idx, 0);
        chk("rst_outst", outst_cnt, 0);
        chk("rst_err", err_unexp_b, 0);
        chk("rst_outs", {s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready, m_bvalid}, 16'h0);
        chk("rst_payload", {s_awaddr, s_wdata}, 64'h0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;

        // 1: master 0 single write, AW and W in the same cycle
        set_mst(0, 1'b1, 1'b1, 1'b1, 32'h1000, 32'hA0);
        #1;
        chk("t1_pre_aw", s_awvalid, 0);
        cyc();
        chk("t1_gvalid", grant_valid, 1);
        chk("t1_gidx", grant_idx, 2'd0);
        chk("t1_s_awvalid", s_awvalid, 1);
        chk("t1_awaddr", s_awaddr, 32'h1000);
        chk("t1_wdata", s_wdata, 32'hA0);
        chk("t1_awready", m_awready, 4'b0001);
        chk("t1_outst_pre", outst_cnt, 3'd0);
        cyc();
        set_mst(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_outst1", outst_cnt, 3'd1);
        chk("t1_idle", grant_valid, 0);
        cyc();
        cyc();
        s_bvalid = 1'b1;
        #1;
        chk("t1_bvalid", m_bvalid, 4'b0001);
        chk("t1_bready", s_bready, 1);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("t1_outst0", outst_cnt, 3'd0);
        chk("t1_bvalid_off", m_bvalid, 4'b0000);

        // 2: round-robin between masters 1 and 2, twice
        do_reset();
        pair_12("t2a");
        pair_12("t2b");

        // 3: master 3, data before address, 4-beat burst, AW ready delayed
        s_awready = 1'b0;
        b0 = beats;
        set_mst(3, 1'b0, 1'b1, 1'b0, 32'h4000, 32'hD0);
        #1;
        chk("t3_w_early0", s_wvalid, 0);
        cyc();
        chk("t3_w_early1", s_wvalid, 0);
        m_awvalid[3] = 1'b1;
        #1;
        chk("t3_w_early2", s_wvalid, 0);
        cyc();
        chk("t3_gidx", grant_idx, 2'd3);
        chk("t3_s_wvalid", s_wvalid, 1);
        chk("t3_wdata0", s_wdata, 32'hD0);
        chk("t3_awready0", m_awready, 4'b0000);
        chk("t3_wready", m_wready, 4'b1000);
        cyc();
        m_wdata[96 +: 32] = 32'hD1;
        #1;
        chk("t3_wdata1", s_wdata, 32'hD1);
        chk("t3_awvalid_wait", s_awvalid, 1);
        cyc();
        m_wdata[96 +: 32] = 32'hD2;
        s_awready = 1'b1;
        #1;
        chk("t3_awready1", m_awready, 4'b1000);
        cyc();
        m_wdata[96 +: 32] = 32'hD3;
        m_wlast[3]   = 1'b1;
        m_awvalid[3] = 1'b0;
        #1;
        chk("t3_aw_done", s_awvalid, 0);
        chk("t3_still_granted", grant_valid, 1);
        chk("t3_outst1", outst_cnt, 3'd1);
        chk("t3_wlast", s_wlast, 1);
        cyc();
        set_mst(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t3_idle", grant_valid, 0);
        chk("t3_beats", beats - b0, 4);
        s_bvalid = 1'b1;
        #1;
        chk("t3_bvalid", m_bvalid, 4'b1000);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("t3_outst0", outst_cnt, 3'd0);

        // 4: fill all outstanding slots, block a fifth request, then drain
        single_write(0, 32'h100, 32'h10);
        single_write(1, 32'h110, 32'h11);
        single_write(2, 32'h120, 32'h12);
        single_write(3, 32'h130, 32'h13);
        chk("t4_full", outst_cnt, 3'd4);
        set_mst(0, 1'b1, 1'b1, 1'b1, 32'h5000, 32'h50);
        #1;
        cyc();
        cyc();
        chk("t4_blocked", grant_valid, 0);
        chk("t4_no_awready", m_awready, 4'b0000);
        s_bvalid = 1'b1;
        #1;
        chk("t4_b0", m_bvalid, 4'b0001);
        chk("t4_bready", s_bready, 1);
        cyc();
        chk("t4_no_grant_at_pop", grant_valid, 0);
        chk("t4_outst3", outst_cnt, 3'd3);
        chk("t4_b1", m_bvalid, 4'b0010);
        cyc();
        chk("t4_grant5", grant_valid, 1);
        chk("t4_grant5_idx", grant_idx, 2'd0);
        chk("t4_b2", m_bvalid, 4'b0100);
        chk("t4_outst2a", outst_cnt, 3'd2);
        cyc();
        set_mst(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t4_outst2b", outst_cnt, 3'd2);
        chk("t4_b3", m_bvalid, 4'b1000);
        chk("t4_idle5", grant_valid, 0);
        cyc();
        chk("t4_b5", m_bvalid, 4'b0001);
        s_bvalid = 1'b0;
        #1;
        chk("t4_outst1", outst_cnt, 3'd1);
        s_bvalid = 1'b1;
        #1;
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("t4_outst0", outst_cnt, 3'd0);

        // 5: unexpected B response with nothing outstanding
        s_bvalid = 1'b1;
        #1;
        chk("t5_bready", s_bready, 0);
        chk("t5_bvalid", m_bvalid, 4'b0000);
        chk("t5_err_pre", err_unexp_b, 0);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("t5_err_set", err_unexp_b, 1);
        single_write(2, 32'h200, 32'h22);
        s_bvalid = 1'b1;
        #1;
        chk("t5_b_m2", m_bvalid, 4'b0100);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("t5_err_held", err_unexp_b, 1);
        chk("t5_outst0", outst_cnt, 3'd0);
        do_reset();
        chk("t5_err_cleared", err_unexp_b, 0);

        // 6: asynchronous reset in the middle of a burst
        single_write(1, 32'h300, 32'h31);
        set_mst(0, 1'b1, 1'b1, 1'b0, 32'h6000, 32'hE0);
        #1;
        cyc();
        chk("t6_gidx", grant_idx, 2'd0);
        cyc();
        m_awvalid[0]      = 1'b0;
        m_wdata[0 +: 32]  = 32'hE1;
        #1;
        chk("t6_outst2a", outst_cnt, 3'd2);
        cyc();
        m_wdata[0 +: 32]  = 32'hE2;
        #1;
        chk("t6_outst2b", outst_cnt, 3'd2);
        chk("t6_mid_burst", grant_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_gvalid", grant_valid, 0);
        chk("t6_rst_outst", outst_cnt, 3'd0);
        chk("t6_rst_outs", {s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready, m_bvalid}, 16'h0);
        set_mst(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        single_write(0, 32'h7000, 32'h70);
        s_bvalid = 1'b1;
        #1;
        chk("t6_b_m0", m_bvalid, 4'b0001);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("t6_outst0", outst_cnt, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
